// File: rtl/spi_to_uart_bridge_pkg.sv
// Shared definitions for the SPI/UART bridge pair: UART FSM encoding, frame size, bit timing.
`timescale 1ns/1ps
package spi_to_uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;

  function automatic int clks_per_bit(input int clock_freq, input int baudrate);
    return clock_freq / baudrate;
  endfunction

endpackage

// File: rtl/spi_to_uart_bridge_uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input; usb_tx is driven straight from a register.
`timescale 1ns/1ps
module spi_to_uart_bridge_uart_tx
  import spi_to_uart_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       usb_tx,
  output logic       active
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  uart_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_done;

  assign bit_done = (cnt == CW'(CLKS_PER_BIT - 1));
  assign active   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Accepting in the last STOP cycle chains frames with no idle gap.
  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (valid) state_nx = START;
      end
      START: if (bit_done) state_nx = DATA;
      DATA:  if (bit_done && idx == 3'd7) state_nx = STOP;
      STOP: begin
        if (bit_done) begin
          ready    = 1'b1;
          state_nx = valid ? START : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      usb_tx <= 1'b1;
    end else if (ready && valid) begin
      shreg  <= data;
      cnt    <= '0;
      idx    <= '0;
      usb_tx <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_done) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          START: usb_tx <= shreg[0];
          DATA: begin
            shreg  <= {1'b0, shreg[7:1]};
            idx    <= idx + 3'd1;
            usb_tx <= (idx == 3'd7) ? 1'b1 : shreg[1];
          end
          default: usb_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/spi_to_uart_bridge.sv
// Mode-0 SPI target that queues received bytes in a small FIFO and sends each one out as an 8N1 UART frame.
`timescale 1ns/1ps
module spi_to_uart_bridge
  import spi_to_uart_bridge_pkg::*;
#(
  parameter int CLOCK_FREQ = 100000000,
  parameter int BAUDRATE   = 625000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SCLK,
  input  logic MOSI,
  input  logic CS,
  output logic usb_tx,
  output logic busy,
  output logic overflow
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUDRATE);
  localparam int PW           = $clog2(FIFO_DEPTH);

  logic [1:0] sclk_s, mosi_s, cs_s;
  logic       sclk_prev, sclk_rise;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       push;
  logic [7:0] rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s    <= '0;
      mosi_s    <= '0;
      cs_s      <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_s    <= {sclk_s[0], SCLK};
      mosi_s    <= {mosi_s[0], MOSI};
      cs_s      <= {cs_s[0], CS};
      sclk_prev <= sclk_s[1];
    end
  end

  assign sclk_rise = sclk_s[1] & ~sclk_prev;
  assign rx_byte   = {shift[6:0], mosi_s[1]};
  assign push      = ~cs_s[1] & sclk_rise & (bit_cnt == 3'd7);

  // Deasserted CS holds the shifter clear, so a partial byte is simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (cs_s[1]) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (sclk_rise) begin
      shift   <= rx_byte;
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  logic [7:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, tx_ready, tx_active;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = tx_ready & ~empty;
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !wr_en) overflow <= 1'b1;
      busy <= tx_active | ~empty;
    end
  end

  spi_to_uart_bridge_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (mem[rd_ptr[PW-1:0]]),
    .valid  (~empty),
    .ready  (tx_ready),
    .usb_tx (usb_tx),
    .active (tx_active)
  );

endmodule
